// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, issues single-outstanding word reads and
// presents one instruction (or a NOP bubble) plus its PC to the decoder.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_imem_err,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_stall,
  output logic        o_instr_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_instr_pc,
  output logic        o_fetch_fault
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_DROP  = 3'd2,
    ST_VALID = 3'd3,
    ST_FAULT = 3'd4
  } state_e;

  state_e      state_r, state_s;
  logic [31:0] pc_r, pc_s;
  logic [31:0] pend_pc_r, pend_pc_s;
  logic [31:0] instr_r, instr_s;
  logic [31:0] drop_tgt_s;

  // A misaligned redirect target faults immediately without touching memory.
  function automatic state_e redirect_state(input logic [31:0] tgt);
    if (tgt[1:0] != 2'b00) begin
      return ST_FAULT;
    end else begin
      return ST_FETCH;
    end
  endfunction

  // State register.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // PC, pending redirect target and held instruction registers.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      pc_r      <= RESET_PC;
      pend_pc_r <= RESET_PC;
      instr_r   <= NOP_INSTR;
    end else begin
      pc_r      <= pc_s;
      pend_pc_r <= pend_pc_s;
      instr_r   <= instr_s;
    end
  end

  // Next-state and datapath update; redirect always takes priority.
  always_comb begin
    state_s    = state_r;
    pc_s       = pc_r;
    pend_pc_s  = pend_pc_r;
    instr_s    = instr_r;
    drop_tgt_s = i_redirect ? i_redirect_pc : pend_pc_r;
    case (state_r)
      ST_IDLE: begin
        state_s = ST_FETCH;
        pc_s    = RESET_PC;
      end
      ST_FETCH: begin
        if (i_redirect) begin
          if (i_imem_ack) begin
            state_s = redirect_state(i_redirect_pc);
            pc_s    = i_redirect_pc;
          end else begin
            state_s   = ST_DROP;
            pend_pc_s = i_redirect_pc;
          end
        end else if (i_imem_ack) begin
          if (i_imem_err) begin
            state_s = ST_FAULT;
          end else begin
            state_s = ST_VALID;
            instr_s = i_imem_rdata;
          end
        end else begin
          state_s = ST_FETCH;
        end
      end
      ST_DROP: begin
        // The outstanding response is discarded; the latest target wins.
        if (i_imem_ack) begin
          state_s = redirect_state(drop_tgt_s);
          pc_s    = drop_tgt_s;
        end else if (i_redirect) begin
          pend_pc_s = i_redirect_pc;
        end else begin
          state_s = ST_DROP;
        end
      end
      ST_VALID: begin
        if (i_redirect) begin
          state_s = redirect_state(i_redirect_pc);
          pc_s    = i_redirect_pc;
        end else if (!i_stall) begin
          state_s = ST_FETCH;
          pc_s    = pc_r + 32'd4;
        end else begin
          state_s = ST_VALID;
        end
      end
      ST_FAULT: begin
        if (i_redirect) begin
          state_s = redirect_state(i_redirect_pc);
          pc_s    = i_redirect_pc;
        end else begin
          state_s = ST_FAULT;
        end
      end
      default: begin
        state_s = ST_IDLE;
        pc_s    = RESET_PC;
      end
    endcase
  end

  // Outputs decoded from state; a NOP is shown whenever no real instruction is held.
  always_comb begin
    o_imem_req    = 1'b0;
    o_instr_valid = 1'b0;
    o_fetch_fault = 1'b0;
    o_instr       = NOP_INSTR;
    o_imem_addr   = pc_r;
    o_instr_pc    = pc_r;
    case (state_r)
      ST_FETCH, ST_DROP: begin
        o_imem_req = 1'b1;
      end
      ST_VALID: begin
        o_instr_valid = 1'b1;
        o_instr       = instr_r;
      end
      ST_FAULT: begin
        o_instr_valid = 1'b1;
        o_fetch_fault = 1'b1;
      end
      default: begin
        o_imem_req = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch: fetch, stall, drop, fault,
// wrap and asynchronous reset scenarios.
module tb_instr_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        i_clk;
  logic        i_rstn;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ack;
  logic [31:0] i_imem_rdata;
  logic        i_imem_err;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        i_stall;
  logic        o_instr_valid;
  logic [31:0] o_instr;
  logic [31:0] o_instr_pc;
  logic        o_fetch_fault;

  int          n_cmp;
  int          n_err;
  logic [98:0] exp_v;

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .i_clk        (i_clk),
    .i_rstn       (i_rstn),
    .o_imem_req   (o_imem_req),
    .o_imem_addr  (o_imem_addr),
    .i_imem_ack   (i_imem_ack),
    .i_imem_rdata (i_imem_rdata),
    .i_imem_err   (i_imem_err),
    .i_redirect   (i_redirect),
    .i_redirect_pc(i_redirect_pc),
    .i_stall      (i_stall),
    .o_instr_valid(o_instr_valid),
    .o_instr      (o_instr),
    .o_instr_pc   (o_instr_pc),
    .o_fetch_fault(o_fetch_fault)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Observed output bundle: {req, addr, valid, instr, instr_pc, fault}
  function automatic logic [98:0] obs();
    return {o_imem_req, o_imem_addr, o_instr_valid, o_instr, o_instr_pc, o_fetch_fault};
  endfunction

  function automatic logic [98:0] exp_reset();
    return {1'b0, 32'h0, 1'b0, NOP, 32'h0, 1'b0};
  endfunction

  function automatic logic [98:0] exp_fetch(input logic [31:0] pc);
    return {1'b1, pc, 1'b0, NOP, pc, 1'b0};
  endfunction

  function automatic logic [98:0] exp_valid(input logic [31:0] pc, input logic [31:0] ins);
    return {1'b0, pc, 1'b1, ins, pc, 1'b0};
  endfunction

  function automatic logic [98:0] exp_fault(input logic [31:0] pc);
    return {1'b0, pc, 1'b1, NOP, pc, 1'b1};
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_rstn = 1'b0; i_imem_ack = 1'b0; i_imem_rdata = 32'h0; i_imem_err = 1'b0;
    i_redirect = 1'b0; i_redirect_pc = 32'h0; i_stall = 1'b0;
    #2;
    exp_v = exp_reset(); n_cmp++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL reset_values: got %h want %h", obs(), exp_v); end
    @(negedge i_clk);
    i_rstn = 1'b1;
    tick();
    exp_v = exp_fetch(32'h0); n_cmp++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL first_req: got %h want %h", obs(), exp_v); end
  endtask

  task automatic test_first_fetch();
    i_imem_ack = 1'b1; i_imem_rdata = 32'h0050_0093;
    tick();
    i_imem_ack = 1'b0;
    exp_v = exp_valid(32'h0, 32'h0050_0093); n_cmp++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL first_valid: got %h want %h", obs(), exp_v); end
    tick();
    exp_v = exp_fetch(32'h4); n_cmp++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL consume_next_req: got %h want %h", obs(), exp_v); end
  endtask

  task automatic test_stall();
    i_imem_ack = 1'b1; i_imem_rdata = 32'h0010_0113; i_stall = 1'b1;
    tick();
    i_imem_ack = 1'b0;
    exp_v = exp_valid(32'h4, 32'h0010_0113); n_cmp++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL stall_enter: got %h want %h", obs(), exp_v); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (obs() !== exp_v) begin n_err++; $display("FAIL stall_hold%0d: got %h want %h", i, obs(), exp_v); end
    end
    i_stall = 1'b0;
    tick();
    exp_v = exp_fetch(32'h8); n_cmp++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL stall_release: got %h want %h", obs(), exp_v); end
  endtask

  task automatic test_drop();
    i_redirect = 1'b1; i_redirect_pc = 32'h0000_0100;
    tick();
    i_redirect_pc = 32'h0000_0200;
    exp_v = exp_fetch(32'h8); n_cmp++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL drop_enter: got %h want %h", obs(), exp_v); end
    tick();
    i_redirect = 1'b0;
    n_cmp++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL drop_addr_hold1: got %h want %h", obs(), exp_v); end
    tick();
    n_cmp++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL drop_addr_hold2: got %h want %h", obs(), exp_v); end
    i_imem_ack = 1'b1; i_imem_rdata = 32'hDEAD_BEEF;
    tick();
    i_imem_ack = 1'b0;
    exp_v = exp_fetch(32'h0000_0200); n_cmp++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL drop_discard: got %h want %h", obs(), exp_v); end
    i_imem_ack = 1'b1; i_imem_rdata = 32'h0000_0293;
    tick();
    i_imem_ack = 1'b0;
    exp_v = exp_valid(32'h0000_0200, 32'h0000_0293); n_cmp++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL drop_new_data: got %h want %h", obs(), exp_v); end
  endtask

  task automatic test_misaligned();
    i_stall = 1'b1; i_redirect = 1'b1; i_redirect_pc = 32'h0000_0102;
    tick();
    i_redirect = 1'b0;
    exp_v = exp_fault(32'h0000_0102); n_cmp++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL misaligned_fault: got %h want %h", obs(), exp_v); end
    for (int i = 0; i < 3; i++) begin
      i_stall = ~i_stall;
      tick();
      n_cmp++;
      if (obs() !== exp_v) begin n_err++; $display("FAIL fault_hold%0d: got %h want %h", i, obs(), exp_v); end
    end
    i_stall = 1'b0; i_redirect = 1'b1; i_redirect_pc = 32'h0000_0200;
    tick();
    i_redirect = 1'b0;
    exp_v = exp_fetch(32'h0000_0200); n_cmp++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL fault_exit: got %h want %h", obs(), exp_v); end
  endtask

  task automatic test_bus_err();
    i_redirect = 1'b1; i_redirect_pc = 32'h0000_0010; i_imem_ack = 1'b1; i_imem_rdata = 32'h1111_1111;
    tick();
    i_redirect = 1'b0; i_imem_ack = 1'b0;
    exp_v = exp_fetch(32'h0000_0010); n_cmp++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL redirect_with_ack: got %h want %h", obs(), exp_v); end
    i_imem_ack = 1'b1; i_imem_err = 1'b1;
    tick();
    i_imem_ack = 1'b0; i_imem_err = 1'b0;
    exp_v = exp_fault(32'h0000_0010); n_cmp++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL bus_err_fault: got %h want %h", obs(), exp_v); end
    i_imem_ack = 1'b1; i_imem_rdata = 32'h2222_2222;
    tick();
    i_imem_ack = 1'b0;
    n_cmp++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL stray_ack_ignored: got %h want %h", obs(), exp_v); end
  endtask

  task automatic test_wrap();
    i_redirect = 1'b1; i_redirect_pc = 32'hFFFF_FFFC;
    tick();
    i_redirect = 1'b0;
    exp_v = exp_fetch(32'hFFFF_FFFC); n_cmp++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL wrap_req: got %h want %h", obs(), exp_v); end
    i_imem_ack = 1'b1; i_imem_rdata = 32'h00A0_0513;
    tick();
    i_imem_ack = 1'b0;
    exp_v = exp_valid(32'hFFFF_FFFC, 32'h00A0_0513); n_cmp++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL wrap_valid: got %h want %h", obs(), exp_v); end
    tick();
    exp_v = exp_fetch(32'h0); n_cmp++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL wrap_next: got %h want %h", obs(), exp_v); end
  endtask

  task automatic test_reset_mid();
    i_imem_ack = 1'b1; i_imem_rdata = 32'h0000_0033;
    tick();
    i_imem_ack = 1'b0; i_redirect = 1'b1; i_redirect_pc = 32'h0000_0300;
    tick();
    i_redirect = 1'b0;
    exp_v = exp_fetch(32'h0000_0300); n_cmp++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL pre_reset_req: got %h want %h", obs(), exp_v); end
    #2;
    i_rstn = 1'b0;
    #1;
    exp_v = exp_reset(); n_cmp++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL async_reset: got %h want %h", obs(), exp_v); end
    @(negedge i_clk);
    i_rstn = 1'b1;
    tick();
    exp_v = exp_fetch(32'h0); n_cmp++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL post_reset_req: got %h want %h", obs(), exp_v); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_first_fetch();
    test_stall();
    test_drop();
    test_misaligned();
    test_bus_err();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
